// File: rtl/mac_sequencer.sv
// Multiply/accumulate job sequencer: walks the multiplier lanes, crossbar and
// accumulators through pass_count passes per job, with a ready timeout.
module mac_sequencer #(
  parameter int IN_PORTS  = 4,
  parameter int OUT_PORTS = 4,
  parameter int ADDR_LEN  = 8,
  parameter int ROUTE_LAT = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic [7:0]           pass_count,
  input  logic [ADDR_LEN-1:0]  route_addr,
  input  logic                 direct_cfg,
  input  logic [OUT_PORTS-1:0] add_mask,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [IN_PORTS-1:0]  m_ready,
  output logic [IN_PORTS-1:0]  m_start,
  output logic [ADDR_LEN-1:0]  addr_sel,
  output logic                 direct,
  output logic [OUT_PORTS-1:0] add,
  output logic                 acc_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           pass_idx
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_OP, START, MULT, ROUTE, ADD, DONE
  } state_t;

  localparam logic [8:0] TMO_LIMIT  = 9'(TIMEOUT);
  localparam logic [3:0] ROUTE_LAST = 4'(ROUTE_LAT - 1);

  state_t               state_q, state_d;
  logic [7:0]           pass_count_q, pass_count_d;
  logic [OUT_PORTS-1:0] add_mask_q, add_mask_d;
  logic [ADDR_LEN-1:0]  addr_sel_q, addr_sel_d;
  logic                 direct_q, direct_d;
  logic [7:0]           pass_idx_q, pass_idx_d;
  logic                 err_q, err_d;
  logic [7:0]           tmo_cnt_q, tmo_cnt_d;
  logic [3:0]           route_cnt_q, route_cnt_d;
  logic                 blank_q, blank_d;

  logic                 op_ready_q, op_ready_d;
  logic [IN_PORTS-1:0]  m_start_q, m_start_d;
  logic [OUT_PORTS-1:0] add_q, add_d;
  logic                 acc_clr_q, acc_clr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d      = state_q;
    pass_count_d = pass_count_q;
    add_mask_d   = add_mask_q;
    addr_sel_d   = addr_sel_q;
    direct_d     = direct_q;
    pass_idx_d   = pass_idx_q;
    err_d        = err_q;
    tmo_cnt_d    = tmo_cnt_q;
    route_cnt_d  = route_cnt_q;
    blank_d      = blank_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          pass_count_d = pass_count;
          add_mask_d   = add_mask;
          addr_sel_d   = route_addr;
          direct_d     = direct_cfg;
          err_d        = 1'b0;
          pass_idx_d   = 8'd0;
          state_d      = (pass_count == 8'd0) ? DONE : CLEAR;
        end
      end
      CLEAR: state_d = WAIT_OP;
      WAIT_OP: begin
        if (op_valid && op_ready_q) state_d = START;
      end
      START: begin
        tmo_cnt_d = 8'd0;
        blank_d   = 1'b1;
        state_d   = MULT;
      end
      MULT: begin
        // The first MULT cycle ignores m_ready so stale ready from the previous
        // operation cannot be mistaken for completion.
        if (blank_q) begin
          blank_d = 1'b0;
        end else if (&m_ready) begin
          route_cnt_d = 4'd0;
          state_d     = ROUTE;
        end else if (({1'b0, tmo_cnt_q} + 9'd1) == TMO_LIMIT) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ROUTE: begin
        if (route_cnt_q == ROUTE_LAST) state_d = ADD;
        else route_cnt_d = route_cnt_q + 4'd1;
      end
      ADD: begin
        if (({1'b0, pass_idx_q} + 9'd1) == {1'b0, pass_count_q}) begin
          state_d = DONE;
        end else begin
          pass_idx_d = pass_idx_q + 8'd1;
          state_d    = WAIT_OP;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    op_ready_d = (state_d == WAIT_OP);
    m_start_d  = (state_d == START) ? {IN_PORTS{1'b1}} : {IN_PORTS{1'b0}};
    add_d      = (state_d == ADD) ? add_mask_d : {OUT_PORTS{1'b0}};
    acc_clr_d  = (state_d == CLEAR);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pass_count_q <= 8'd0;
      add_mask_q   <= '0;
      addr_sel_q   <= '0;
      direct_q     <= 1'b0;
      pass_idx_q   <= 8'd0;
      err_q        <= 1'b0;
      tmo_cnt_q    <= 8'd0;
      route_cnt_q  <= 4'd0;
      blank_q      <= 1'b0;
      op_ready_q   <= 1'b0;
      m_start_q    <= '0;
      add_q        <= '0;
      acc_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_count_q <= pass_count_d;
      add_mask_q   <= add_mask_d;
      addr_sel_q   <= addr_sel_d;
      direct_q     <= direct_d;
      pass_idx_q   <= pass_idx_d;
      err_q        <= err_d;
      tmo_cnt_q    <= tmo_cnt_d;
      route_cnt_q  <= route_cnt_d;
      blank_q      <= blank_d;
      op_ready_q   <= op_ready_d;
      m_start_q    <= m_start_d;
      add_q        <= add_d;
      acc_clr_q    <= acc_clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign op_ready = op_ready_q;
  assign m_start  = m_start_q;
  assign addr_sel = addr_sel_q;
  assign direct   = direct_q;
  assign add      = add_q;
  assign acc_clr  = acc_clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign pass_idx = pass_idx_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised self-checking bench for mac_sequencer; a pass-level timing model
// predicts job length, pulse counts and error outcome for each job.
module tb_mac_sequencer;

   localparam int IN_PORTS  = 4;
   localparam int OUT_PORTS = 4;
   localparam int ADDR_LEN  = 8;
   localparam int RL        = 1;
   localparam int TMO       = 8;
   localparam int BUDGET    = 2000;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 go = 1'b0;
   logic [7:0]           pass_count = 8'd0;
   logic [ADDR_LEN-1:0]  route_addr = '0;
   logic                 direct_cfg = 1'b0;
   logic [OUT_PORTS-1:0] add_mask = '0;
   logic                 op_valid = 1'b0;
   logic                 op_ready;
   logic [IN_PORTS-1:0]  m_ready = '0;
   logic [IN_PORTS-1:0]  m_start;
   logic [ADDR_LEN-1:0]  addr_sel;
   logic                 direct;
   logic [OUT_PORTS-1:0] add;
   logic                 acc_clr;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [7:0]           pass_idx;

   int total = 0;
   int bad = 0;

   // Per-pass stimulus: cycles op_valid is held low once op_ready rises, and the
   // MULT cycle in which m_ready turns all-ones (0 = already high, -1 = stuck).
   int gaps[16];
   int delays[16];

   mac_sequencer #(
      .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS), .ADDR_LEN(ADDR_LEN),
      .ROUTE_LAT(RL), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .pass_count(pass_count),
      .route_addr(route_addr), .direct_cfg(direct_cfg), .add_mask(add_mask),
      .op_valid(op_valid), .op_ready(op_ready), .m_ready(m_ready),
      .m_start(m_start), .addr_sel(addr_sel), .direct(direct), .add(add),
      .acc_clr(acc_clr), .busy(busy), .done(done), .err(err), .pass_idx(pass_idx)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      total++;
      if (got !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, expected);
      end
   endtask

   function automatic logic [31:0] allOutputs();
      return {8'(m_start), 8'(add), acc_clr, op_ready, busy, done, err, direct,
              2'b00, pass_idx ^ addr_sel};
   endfunction

   // Runs one job from go to the idle cycle after done, driving operands and
   // multiplier readiness per pass and comparing against the pass-level model
   task automatic applyStimulus(input logic [7:0] pc, input logic [ADDR_LEN-1:0] ra,
                                input logic dc, input logic [OUT_PORTS-1:0] mask,
                                input bit disturb);
      int exp_total, exp_starts, exp_adds, exp_rdy, exp_last, w, k, m;
      bit exp_err;
      int n_clr, n_start, n_add, n_rdy, bad_val, bad_busy, bad_cfg, done_cyc;
      int gap_left, hs, ms, rdy_left;
      logic err0;

      exp_total = 0; exp_starts = 0; exp_adds = 0; exp_rdy = 0; exp_last = 0;
      exp_err = 1'b0;
      if (pc != 0) begin
         exp_total = 1;
         for (int i = 0; i < int'(pc); i++) begin
            w = gaps[i] + 1;
            k = delays[i];
            exp_rdy += w;
            exp_starts++;
            exp_last = i;
            if (k < 0 || k > 1 + TMO) begin
               exp_total += w + 1 + 1 + TMO;
               exp_err = 1'b1;
               break;
            end
            m = (k < 2) ? 2 : k;
            exp_total += w + 1 + m + RL + 1;
            exp_adds++;
         end
      end

      @(negedge clk);
      go = 1'b1; pass_count = pc; route_addr = ra; direct_cfg = dc; add_mask = mask;
      op_valid = (gaps[0] == 0); m_ready = '0;
      gap_left = gaps[0]; hs = 0; ms = 0; rdy_left = 0;
      n_clr = 0; n_start = 0; n_add = 0; n_rdy = 0;
      bad_val = 0; bad_busy = 0; bad_cfg = 0; done_cyc = -1; err0 = 1'b1;

      for (int cyc = 0; cyc < BUDGET && done_cyc < 0; cyc++) begin
         @(negedge clk);
         if (cyc == 0) err0 = err;
         if (acc_clr) n_clr++;
         if (m_start != '0) begin
            n_start++;
            if (m_start !== '1) bad_val++;
         end
         if (add != '0) begin
            if (add !== mask || pass_idx !== 8'(n_add)) bad_val++;
            n_add++;
         end
         if (op_ready) n_rdy++;
         if (busy !== 1'b1) bad_busy++;
         if (addr_sel !== ra || direct !== dc) bad_cfg++;
         if (done) done_cyc = cyc;

         go = 1'b0;
         if (disturb && !done && $urandom_range(0, 1) == 1) begin
            go = 1'b1;
            pass_count = 8'($urandom);
            route_addr = ADDR_LEN'($urandom);
            direct_cfg = 1'($urandom);
            add_mask   = OUT_PORTS'($urandom);
         end

         if (op_ready) begin
            if (gap_left > 0) begin
               op_valid = 1'b0;
               gap_left--;
            end else begin
               op_valid = 1'b1;
               hs++;
               gap_left = gaps[(hs < 16) ? hs : 15];
            end
         end

         if (m_start != '0) begin
            k = delays[(ms < 16) ? ms : 15];
            ms++;
            rdy_left = 0;
            if (k < 0) m_ready = 4'b0111;
            else if (k == 0) m_ready = '1;
            else begin
               m_ready = '0;
               rdy_left = k;
            end
         end else if (rdy_left > 0) begin
            rdy_left--;
            if (rdy_left == 0) m_ready = '1;
         end
      end

      checkOutput("done_latency", 32'(done_cyc), 32'(exp_total));
      checkOutput("err_cleared_at_go", 32'(err0), 32'(0));
      checkOutput("acc_clr_pulses", 32'(n_clr), 32'((pc != 0) ? 1 : 0));
      checkOutput("m_start_pulses", 32'(n_start), 32'(exp_starts));
      checkOutput("add_pulses", 32'(n_add), 32'(exp_adds));
      checkOutput("op_ready_cycles", 32'(n_rdy), 32'(exp_rdy));
      checkOutput("pulse_values", 32'(bad_val), 32'(0));
      checkOutput("busy_during_job", 32'(bad_busy), 32'(0));
      checkOutput("config_held", 32'(bad_cfg), 32'(0));

      @(negedge clk);
      checkOutput("idle_busy_done", {30'd0, busy, done}, 32'(0));
      checkOutput("err_sticky", 32'(err), 32'(exp_err));
      checkOutput("pass_idx_held", 32'(pass_idx), 32'(exp_last));
      op_valid = 1'b0;
   endtask

   // Starts a two-pass job, pulls reset while the crossbar is settling and
   // confirms everything clears at once and stays quiet across release
   task automatic resetDuringRoute();
      @(negedge clk);
      go = 1'b1; pass_count = 8'd2; route_addr = 8'hC3; direct_cfg = 1'b1;
      add_mask = 4'b1010; op_valid = 1'b1; m_ready = '1;
      @(negedge clk);
      go = 1'b0;
      // CLEAR at cycle 0, WAIT_OP 1, START 2, MULT 3-4, ROUTE 5
      repeat (5) @(negedge clk);
      checkOutput("busy_before_reset", 32'(busy), 32'(1));
      checkOutput("addr_before_reset", 32'(addr_sel), 32'(8'hC3));
      #1 rst_n = 1'b0;
      #1 checkOutput("async_reset_outputs", allOutputs(), 32'(0));
      @(negedge clk);
      rst_n = 1'b1; op_valid = 1'b0; m_ready = '0;
      @(negedge clk);
      checkOutput("release_quiet", allOutputs(), 32'(0));
   endtask

   initial begin
      int r;
      #12;
      checkOutput("reset_outputs", allOutputs(), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_release_idle", allOutputs(), 32'(0));

      // Single pass, operands ready, m_ready on the 2nd MULT cycle
      foreach (gaps[i]) begin gaps[i] = 0; delays[i] = 2; end
      applyStimulus(8'd1, 8'h5A, 1'b0, 4'b1111, 1'b0);

      // Three passes with the host stalling before the second pass
      gaps[1] = 4;
      applyStimulus(8'd3, 8'h33, 1'b1, 4'b0110, 1'b1);

      // Multiplier never fully ready: timeout, then a clean job clears err
      foreach (gaps[i]) begin gaps[i] = 0; delays[i] = -1; end
      applyStimulus(8'd2, 8'h81, 1'b0, 4'b1111, 1'b0);
      foreach (delays[i]) delays[i] = 0;
      applyStimulus(8'd2, 8'h18, 1'b1, 4'b1001, 1'b0);

      // Zero-pass job with go toggled while busy
      applyStimulus(8'd0, 8'hE7, 1'b1, 4'b1111, 1'b1);

      resetDuringRoute();
      foreach (delays[i]) delays[i] = 3;
      applyStimulus(8'd1, 8'h42, 1'b0, 4'b0011, 1'b0);

      for (int job = 0; job < 30; job++) begin
         foreach (gaps[i]) begin
            gaps[i] = $urandom_range(0, 3);
            r = $urandom_range(0, 15);
            delays[i] = (r == 15) ? -1 : ((r >= 13) ? r - 3 : r % 6);
         end
         applyStimulus(8'($urandom_range(0, 5)), ADDR_LEN'($urandom), 1'($urandom),
                       OUT_PORTS'($urandom_range(1, 15)), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
